fire3_concat_writer: RTL and testbench

// - Downstream of the fire3 expand 1x1 and expand 3x3 stages. Captures each stage's
//   per-pixel vector of CHOUT ReLU'd activations and writes it to the fire3 output

---
 rtl/fire3_pkg.sv | 38 +++
 rtl/concat_capture_bank.sv | 61 ++++++
 rtl/fire3_concat_writer.sv | 151 +++++++++++++++
 tb/tb_fire3_concat_writer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire3_pkg.sv
// Shared constants, types and the output address helper for the fire3
// concatenating output writer.
package fire3_pkg;

  localparam int WIDTH    = 16;
  localparam int CHOUT    = 64;
  localparam int W_IN     = 16;
  localparam int H_IN     = 16;
  localparam int WR_LANES = 8;

  localparam int NPIX   = W_IN * H_IN;
  localparam int BEATS  = CHOUT / WR_LANES;
  localparam int ADDR_W = $clog2(NPIX * 2 * CHOUT);
  localparam int PCNT_W = $clog2(NPIX + 1);
  localparam int PIX_W  = $clog2(NPIX);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CH_W   = $clog2(CHOUT);
  localparam int LANE_W = WIDTH * WR_LANES;

  typedef logic [WIDTH-1:0] act_t;

  typedef enum logic [1:0] {IDLE, DRAIN1, DRAIN3, DONE} cw_state_t;

  // Word address of lane 0 for one beat: pixels are 2*CHOUT words apart,
  // expand3 occupies the upper CHOUT words of each pixel.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [PIX_W-1:0]  pix,
                                                  input logic              b3,
                                                  input logic [BEAT_W-1:0] beat);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] off;
    base = ADDR_W'(pix) * ADDR_W'(2 * CHOUT);
    half = b3 ? ADDR_W'(CHOUT) : '0;
    off  = ADDR_W'(beat) * ADDR_W'(WR_LANES);
    return base + half + off;
  endfunction

endpackage

// File: rtl/concat_capture_bank.sv
// One capture bank: holds a single pixel vector from one expand branch until
// the writer has streamed it out, and counts how many pixels were accepted.
module concat_capture_bank
  import fire3_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  valid,
  input  act_t [CHOUT-1:0]      ofm,
  input  logic                  free,
  input  logic [BEAT_W-1:0]     beat,
  output logic                  full,
  output logic                  cap,
  output logic                  ovf,
  output logic [PCNT_W-1:0]     pcnt,
  output logic [PIX_W-1:0]      pix,
  output logic [LANE_W-1:0]     lanes
);

  act_t [CHOUT-1:0] vec;
  logic             room;

  // A bank being freed on this edge can take a new vector on the same edge,
  // so the last beat and the next capture overlap without a bubble.
  assign room = pcnt < PCNT_W'(NPIX);
  assign cap  = valid && en && room && (!full || free);
  assign ovf  = valid && en && room && full && !free;

  // Occupancy flag and pixel counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      pcnt <= '0;
      pix  <= '0;
    end else if (cap) begin
      full <= 1'b1;
      pix  <= pcnt[PIX_W-1:0];
      pcnt <= pcnt + 1'b1;
    end else if (free) begin
      full <= 1'b0;
    end
  end

  // Vector storage; contents are only meaningful while full is set
  always_ff @(posedge clk) begin
    if (cap) vec <= ofm;
  end

  // Select the WR_LANES channels belonging to the requested beat
  always_comb begin
    logic [CH_W-1:0] idx;
    lanes = '0;
    idx   = '0;
    for (int l = 0; l < WR_LANES; l++) begin
      idx = CH_W'(int'(beat) * WR_LANES + l);
      lanes[l*WIDTH +: WIDTH] = vec[idx];
    end
  end

endmodule

// File: rtl/fire3_concat_writer.sv
// Concatenating output writer for fire3: captures expand1/expand3 pixel
// vectors and streams them to the output RAM, WR_LANES words per beat.
//
// state  | meaning
// IDLE   | no bank being drained; starts a drain (issuing beat 0) when a bank is full
// DRAIN1 | streaming expand1 bank, beat counter k is the next beat to issue
// DRAIN3 | streaming expand3 bank, beat counter k is the next beat to issue
// DONE   | every pixel of both branches written; layer_end held until reset
module fire3_concat_writer
  import fire3_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 exp1_valid,
  input  act_t [CHOUT-1:0]     exp1_ofm,
  input  logic                 exp3_valid,
  input  act_t [CHOUT-1:0]     exp3_ofm,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [LANE_W-1:0]    wr_data,
  output logic                 layer_end,
  output logic                 overflow
);

  cw_state_t         state;
  cw_state_t         after;
  logic [BEAT_W-1:0] k;

  logic              issue;
  logic              issue_b3;
  logic [BEAT_W-1:0] issue_k;
  logic              last_beat;
  logic              free1, free3;

  logic              full1, full3, cap1, cap3, ovf1, ovf3;
  logic [PCNT_W-1:0] pcnt1, pcnt3;
  logic [PIX_W-1:0]  pix1, pix3;
  logic [LANE_W-1:0] lanes1, lanes3;

  concat_capture_bank u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .valid (exp1_valid),
    .ofm   (exp1_ofm),
    .free  (free1),
    .beat  (issue_k),
    .full  (full1),
    .cap   (cap1),
    .ovf   (ovf1),
    .pcnt  (pcnt1),
    .pix   (pix1),
    .lanes (lanes1)
  );

  concat_capture_bank u_bank3 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .valid (exp3_valid),
    .ofm   (exp3_ofm),
    .free  (free3),
    .beat  (issue_k),
    .full  (full3),
    .cap   (cap3),
    .ovf   (ovf3),
    .pcnt  (pcnt3),
    .pix   (pix3),
    .lanes (lanes3)
  );

  // Which bank/beat goes out on this edge; IDLE issues beat 0 directly so
  // the first beat appears one cycle after the capture edge.
  always_comb begin
    issue    = 1'b0;
    issue_b3 = 1'b0;
    issue_k  = k;
    case (state)
      IDLE: begin
        issue_k = '0;
        if (full1) begin
          issue = 1'b1;
        end else if (full3) begin
          issue    = 1'b1;
          issue_b3 = 1'b1;
        end
      end
      DRAIN1: issue = 1'b1;
      DRAIN3: begin
        issue    = 1'b1;
        issue_b3 = 1'b1;
      end
      default: issue = 1'b0;
    endcase
  end

  assign last_beat = issue && (issue_k == BEAT_W'(BEATS - 1));
  assign free1     = last_beat && !issue_b3;
  assign free3     = last_beat && issue_b3;

  // Round-robin successor after a bank's last beat: the other bank first,
  // then the same bank if it is being refilled on this very edge.
  always_comb begin
    after = IDLE;
    if (issue_b3) begin
      if (full1)     after = DRAIN1;
      else if (cap3) after = DRAIN3;
    end else begin
      if (full3)     after = DRAIN3;
      else if (cap1) after = DRAIN1;
    end
  end

  // Writer FSM with registered RAM write port and sticky status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      layer_end <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ovf1 || ovf3) overflow <= 1'b1;
      wr_en <= issue;
      if (issue) begin
        wr_addr <= beat_addr(issue_b3 ? pix3 : pix1, issue_b3, issue_k);
        wr_data <= issue_b3 ? lanes3 : lanes1;
      end
      case (state)
        DONE: layer_end <= 1'b1;
        default: begin
          if (issue) begin
            if (last_beat) begin
              state <= after;
              k     <= '0;
            end else begin
              state <= issue_b3 ? DRAIN3 : DRAIN1;
              k     <= issue_k + 1'b1;
            end
          end else if (pcnt1 == PCNT_W'(NPIX) && pcnt3 == PCNT_W'(NPIX)) begin
            state <= DONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fire3_concat_writer.sv
// Bench for fire3_concat_writer: directed latency/boundary cases plus
// randomized vectors checked against an address-indexed output store.
module tb_fire3_concat_writer;
  import fire3_pkg::*;

  typedef logic [CHOUT-1:0][WIDTH-1:0] vec_t;

  logic              clk;
  logic              rst;
  logic              en;
  logic              exp1_valid;
  logic              exp3_valid;
  vec_t              exp1_ofm;
  vec_t              exp3_ofm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANE_W-1:0] wr_data;
  logic              layer_end;
  logic              overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [ADDR_W-1:0] q_addr[$];
  logic [LANE_W-1:0] q_data[$];
  int                q_cyc[$];

  vec_t store1[int];
  vec_t store3[int];

  fire3_concat_writer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .exp1_valid (exp1_valid),
    .exp1_ofm   (exp1_ofm),
    .exp3_valid (exp3_valid),
    .exp3_ofm   (exp3_ofm),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .layer_end  (layer_end),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && wr_en) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [LANE_W-1:0] got,
                           input logic [LANE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANE_W-1:0] exp_lanes(input vec_t v, input int k);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int l = 0; l < WR_LANES; l++) r[l*WIDTH +: WIDTH] = v[k*WR_LANES + l];
    return r;
  endfunction

  function automatic vec_t ramp(input int base);
    vec_t v;
    for (int i = 0; i < CHOUT; i++) v[i] = WIDTH'(base + i);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < CHOUT; i++) v[i] = WIDTH'($urandom);
    return v;
  endfunction

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp1_valid = 1'b0;
    exp3_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_q();
  endtask

  // Pulse one branch's valid for exactly the cycle numbered 'at'
  task automatic send(input bit b3, input int at, input vec_t v);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < at);
    if (b3) begin
      exp3_ofm = v;
      exp3_valid = 1'b1;
    end else begin
      exp1_ofm = v;
      exp1_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if (b3) exp3_valid = 1'b0;
    else    exp1_valid = 1'b0;
  endtask

  task automatic check_burst(input string tag, input int idx0, input int c0,
                             input int a0, input vec_t v);
    for (int k = 0; k < BEATS; k++) begin
      if (idx0 + k < q_addr.size()) begin
        check_val({tag, "_cyc"},  LANE_W'(q_cyc[idx0+k]), LANE_W'(c0 + k));
        check_val({tag, "_addr"}, LANE_W'(q_addr[idx0+k]), LANE_W'(a0 + k*WR_LANES));
        check_val({tag, "_data"}, q_data[idx0+k], exp_lanes(v, k));
      end
    end
  endtask

  // Every write must land on a distinct, lane-aligned beat of an issued pixel
  // and carry exactly that pixel's channel slice.
  task automatic verify_store(input string tag, input int npix);
    bit seen[int];
    check_val({tag, "_nwr"}, LANE_W'(q_addr.size()), LANE_W'(2 * npix * BEATS));
    foreach (q_addr[i]) begin
      int a, p, b, k;
      a = int'(q_addr[i]);
      p = a / (2 * CHOUT);
      b = (a / CHOUT) % 2;
      k = (a % CHOUT) / WR_LANES;
      check_val({tag, "_align"}, LANE_W'(a % WR_LANES), '0);
      check_val({tag, "_pix"}, LANE_W'(p < npix), LANE_W'(1));
      if (p < npix) begin
        check_val({tag, "_dup"}, LANE_W'(seen.exists(a)), '0);
        seen[a] = 1'b1;
        check_val({tag, "_data"}, q_data[i],
                  exp_lanes(b == 1 ? store3[p] : store1[p], k));
      end
    end
  endtask

  task automatic run_branch(input bit b3, input int n);
    int at;
    vec_t v;
    at = cyc + int'($urandom_range(1, 8));
    for (int p = 0; p < n; p++) begin
      v = rand_vec();
      if (b3) store3[p] = v;
      else    store1[p] = v;
      send(b3, at, v);
      at = at + int'($urandom_range(17, 40));
    end
  endtask

  initial begin
    vec_t a, b, c;
    int t;
    int at;

    rst = 1'b0;
    en = 1'b1;
    exp1_valid = 1'b0;
    exp3_valid = 1'b0;
    exp1_ofm = '0;
    exp3_ofm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_wr_en",     LANE_W'(wr_en), '0);
    check_val("rst_wr_addr",   LANE_W'(wr_addr), '0);
    check_val("rst_wr_data",   wr_data, '0);
    check_val("rst_layer_end", LANE_W'(layer_end), '0);
    check_val("rst_overflow",  LANE_W'(overflow), '0);

    // single expand1 vector
    do_reset();
    a = ramp(0);
    t = cyc + 2;
    send(0, t, a);
    idle(14);
    check_val("t1_count", LANE_W'(q_addr.size()), LANE_W'(BEATS));
    check_burst("t1", 0, t + 2, 0, a);
    check_val("t1_wr_en_low", LANE_W'(wr_en), '0);

    // single expand3 vector
    do_reset();
    a = ramp(100);
    t = cyc + 2;
    send(1, t, a);
    idle(14);
    check_val("t2_count", LANE_W'(q_addr.size()), LANE_W'(BEATS));
    check_burst("t2", 0, t + 2, CHOUT, a);

    // both branches in the same cycle
    do_reset();
    a = rand_vec();
    b = rand_vec();
    t = cyc + 2;
    fork
      send(0, t, a);
      send(1, t, b);
    join
    idle(22);
    check_val("t3_count", LANE_W'(q_addr.size()), LANE_W'(2 * BEATS));
    check_burst("t3a", 0, t + 2, 0, a);
    check_burst("t3b", BEATS, t + 2 + BEATS, CHOUT, b);

    // second expand1 vector while the bank is still full
    do_reset();
    a = rand_vec();
    b = rand_vec();
    c = rand_vec();
    t = cyc + 2;
    send(0, t, a);
    send(0, t + 3, b);
    idle(15);
    check_val("t4_overflow", LANE_W'(overflow), LANE_W'(1));
    check_val("t4_count", LANE_W'(q_addr.size()), LANE_W'(BEATS));
    check_burst("t4a", 0, t + 2, 0, a);
    t = cyc + 2;
    send(0, t, c);
    idle(14);
    check_val("t4_count2", LANE_W'(q_addr.size()), LANE_W'(2 * BEATS));
    check_burst("t4c", BEATS, t + 2, 2 * CHOUT, c);

    // valid on the last-beat edge of the same bank
    do_reset();
    a = rand_vec();
    b = rand_vec();
    t = cyc + 2;
    send(0, t, a);
    send(0, t + BEATS, b);
    idle(16);
    check_val("t5_overflow", LANE_W'(overflow), '0);
    check_val("t5_count", LANE_W'(q_addr.size()), LANE_W'(2 * BEATS));
    check_burst("t5a", 0, t + 2, 0, a);
    check_burst("t5b", BEATS, t + 2 + BEATS, 2 * CHOUT, b);

    // en gates captures but not a drain in progress
    do_reset();
    en = 1'b0;
    a = rand_vec();
    b = rand_vec();
    send(0, cyc + 2, a);
    idle(12);
    check_val("t6_blocked", LANE_W'(q_addr.size()), '0);
    check_val("t6_no_ovf", LANE_W'(overflow), '0);
    en = 1'b1;
    t = cyc + 2;
    send(0, t, b);
    en = 1'b0;
    idle(12);
    check_val("t6_count", LANE_W'(q_addr.size()), LANE_W'(BEATS));
    check_burst("t6b", 0, t + 2, 0, b);
    en = 1'b1;

    // reset in the middle of a drain
    do_reset();
    a = rand_vec();
    b = rand_vec();
    t = cyc + 2;
    send(0, t, a);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < t + 5);
    check_val("t7_mid_wr_en", LANE_W'(wr_en), LANE_W'(1));
    #2 rst = 1'b0;
    #1;
    check_val("t7_rst_wr_en", LANE_W'(wr_en), '0);
    check_val("t7_rst_addr", LANE_W'(wr_addr), '0);
    @(posedge clk);
    #1 rst = 1'b1;
    clear_q();
    t = cyc + 2;
    send(0, t, b);
    idle(14);
    check_val("t7_count", LANE_W'(q_addr.size()), LANE_W'(BEATS));
    check_burst("t7b", 0, t + 2, 0, b);

    // independent random arrival times on both branches
    do_reset();
    store1.delete();
    store3.delete();
    fork
      run_branch(0, 40);
      run_branch(1, 40);
    join
    idle(50);
    verify_store("t8", 40);
    check_val("t8_overflow", LANE_W'(overflow), '0);
    check_val("t8_layer_end", LANE_W'(layer_end), '0);

    // full layer at the minimum sustained period
    do_reset();
    store1.delete();
    store3.delete();
    at = cyc + 2;
    for (int p = 0; p < NPIX; p++) begin
      a = rand_vec();
      b = rand_vec();
      store1[p] = a;
      store3[p] = b;
      fork
        send(0, at, a);
        send(1, at, b);
      join
      at = at + 17;
    end
    idle(60);
    verify_store("t9", NPIX);
    if (q_addr.size() > 0)
      check_val("t9_last_addr", LANE_W'(q_addr[q_addr.size()-1]), LANE_W'(32760));
    check_val("t9_overflow", LANE_W'(overflow), '0);
    check_val("t9_layer_end", LANE_W'(layer_end), LANE_W'(1));
    clear_q();
    fork
      send(0, cyc + 2, rand_vec());
      send(1, cyc + 3, rand_vec());
    join
    idle(20);
    check_val("t9_no_more", LANE_W'(q_addr.size()), '0);
    check_val("t9_end_held", LANE_W'(layer_end), LANE_W'(1));
    check_val("t9_no_ovf_after", LANE_W'(overflow), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
